// File: rtl/loop_seq_ctrl.sv
// rtl/loop_seq_ctrl.sv - bounded counting loop sequencer with abort and completion pulse
module loop_seq_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    input  logic             step_en,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_vld,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_inc;
    logic             vld_d;
    logic             aborted_d;

    // Incremented count used both as the next value and for the terminal compare;
    // lim_q never exceeds the counter range, so the compare stops it before any wrap.
    assign count_inc = count + 1'b1;

    // State and registered outputs; busy/done are decoded from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lim_q     <= '0;
            count     <= '0;
            count_vld <= 1'b0;
            aborted   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            lim_q     <= lim_d;
            count     <= count_d;
            count_vld <= vld_d;
            aborted   <= aborted_d;
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
        end
    end

    // Next-state logic: accept start only in IDLE; in RUN abort beats a same-cycle step.
    always_comb begin
        state_d   = state;
        lim_d     = lim_q;
        count_d   = count;
        vld_d     = 1'b0;
        aborted_d = aborted;
        case (state)
            IDLE: begin
                if (start) begin
                    lim_d     = limit;
                    count_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = (limit == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (step_en) begin
                    count_d = count_inc;
                    vld_d   = 1'b1;
                    if (count_inc == lim_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// tb/tb_loop_seq_ctrl.sv - directed self-checking bench for loop_seq_ctrl
module tb_loop_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] limit;
    logic       step_en;
    logic       abort;
    logic       busy;
    logic [3:0] count;
    logic       count_vld;
    logic       done;
    logic       aborted;

    int total;
    int bad;
    int vld_n;
    int exp_cnt;

    loop_seq_ctrl #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .limit     (limit),
        .step_en   (step_en),
        .abort     (abort),
        .busy      (busy),
        .count     (count),
        .count_vld (count_vld),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        limit   = 4'd0;
        step_en = 1'b0;
        abort   = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_vld", count_vld, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        rst_n = 1'b1;
        tick();

        // 1: limit=10, step held high
        start = 1'b1; limit = 4'd10; step_en = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy0", busy, 1);
        chk("t1_count0", count, 0);
        chk("t1_vld0", count_vld, 0);
        vld_n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("t1_count", count, i);
            chk("t1_done", done, (i == 10) ? 1 : 0);
            vld_n += int'(count_vld);
        end
        chk("t1_vld_n", vld_n, 10);
        chk("t1_aborted", aborted, 0);
        tick();
        chk("t1_done_end", done, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_count_hold", count, 10);
        chk("t1_vld_end", count_vld, 0);

        // 2: limit=0 finishes with no iterations
        step_en = 1'b0; start = 1'b1; limit = 4'd0;
        tick();
        start = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_count", count, 0);
        chk("t2_vld", count_vld, 0);
        chk("t2_busy", busy, 1);
        tick();
        chk("t2_busy_end", busy, 0);
        chk("t2_done_end", done, 0);

        // 3: limit=3 with step_en alternating
        start = 1'b1; limit = 4'd3;
        tick();
        start = 1'b0;
        exp_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step_en = (c % 2 == 0);
            exp_cnt += (c % 2 == 0) ? 1 : 0;
            tick();
            chk("t3_count", count, exp_cnt);
            chk("t3_vld", count_vld, (c % 2 == 0) ? 1 : 0);
        end
        step_en = 1'b0;
        chk("t3_done", done, 1);
        tick();
        chk("t3_busy_end", busy, 0);

        // 4: abort at count 4 with a same-cycle step
        start = 1'b1; limit = 4'd10; step_en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_count_pre", count, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0; step_en = 1'b0;
        chk("t4_count", count, 4);
        chk("t4_done", done, 1);
        chk("t4_aborted", aborted, 1);
        chk("t4_vld", count_vld, 0);
        tick();
        chk("t4_aborted_hold", aborted, 1);
        chk("t4_busy", busy, 0);
        start = 1'b1; limit = 4'd1;
        tick();
        start = 1'b0;
        chk("t4_aborted_clr", aborted, 0);
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        chk("t4_rerun_done", done, 1);
        chk("t4_rerun_count", count, 1);
        tick();

        // 5: start/limit during RUN are ignored; limit=15 does not wrap
        start = 1'b1; limit = 4'd5; step_en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; limit = 4'd2;
        tick();
        chk("t5_count3", count, 3);
        tick();
        start = 1'b0;
        chk("t5_count4", count, 4);
        chk("t5_done4", done, 0);
        tick();
        chk("t5_count5", count, 5);
        chk("t5_done", done, 1);
        step_en = 1'b0;
        tick();
        start = 1'b1; limit = 4'd15; step_en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t5_count15", count, 15);
        chk("t5_done15", done, 1);
        tick();
        chk("t5_nowrap", count, 15);
        chk("t5_busy_end", busy, 0);
        tick();
        chk("t5_idle_step", count, 15);
        step_en = 1'b0;

        // 6: async reset mid-loop, then a normal run
        start = 1'b1; limit = 4'd10; step_en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_count_pre", count, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_count_rst", count, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_vld_rst", count_vld, 0);
        vld_n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vld_n += int'(done);
        end
        chk("t6_no_done", vld_n, 0);
        rst_n = 1'b1;
        tick();
        start = 1'b1; limit = 4'd2;
        tick();
        start = 1'b0;
        tick();
        chk("t6_count1", count, 1);
        tick();
        chk("t6_count2", count, 2);
        chk("t6_done", done, 1);
        step_en = 1'b0;
        tick();
        chk("t6_busy_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
